// File: rtl/launcher_pkg.sv
// Shared types and widths for the program launcher: FSM states, data-memory
// write payload, byte/address width and RUN cycle-counter width.
package launcher_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CYC_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_CRST = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    typedef struct packed {
        logic [BYTE_W-1:0] addr;
        logic [BYTE_W-1:0] wdat;
    } dm_wr_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module sat_counter
    import launcher_pkg::*;
#(
    parameter int unsigned W = CYC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clear,
    input  logic         i_enable,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Clear has priority over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/prog_launcher.sv
// Preloads LOAD_LEN bytes into the core's data memory, pulses core reset,
// then lets the core run until it reports done or the cycle budget expires.
module prog_launcher
    import launcher_pkg::*;
#(
    parameter int unsigned LOAD_LEN = 64,
    parameter int unsigned TIMEOUT  = 4095
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_in_valid,
    input  logic [BYTE_W-1:0] i_in_data,
    output logic              o_in_ready,
    output logic              o_dm_wen,
    output logic [BYTE_W-1:0] o_dm_addr,
    output logic [BYTE_W-1:0] o_dm_wdat,
    output logic              o_core_reset,
    input  logic              i_core_done,
    output logic              o_busy,
    output logic              o_finished,
    output logic              o_timed_out,
    output logic [CYC_W-1:0]  o_cycles
);

    // Index is one bit wider than the address so LOAD_LEN=256 is reachable.
    localparam int unsigned     IDX_W    = BYTE_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((LOAD_LEN == 0) ? 0 : LOAD_LEN - 1);
    localparam logic [CYC_W-1:0] TO_LAST  = CYC_W'(TIMEOUT - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [IDX_W-1:0]   r_idx;
    logic               r_crst_cnt;
    dm_wr_t             r_dm;
    logic               r_dm_wen;
    logic               r_core_reset;
    logic               r_finished;
    logic               r_timed_out;
    logic [CYC_W-1:0]   w_cycles;
    logic               w_xfer;
    logic               w_launch;
    logic               w_timeout;

    assign w_xfer    = (r_state == ST_LOAD) && i_in_valid;
    assign w_launch  = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && i_start;
    assign w_timeout = (w_cycles == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_next_state = (LOAD_LEN == 0) ? ST_CRST : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_xfer && (r_idx == LAST_IDX)) begin
                    w_next_state = ST_CRST;
                end
            end
            ST_CRST: begin
                if (r_crst_cnt) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_core_done || w_timeout) begin
                    w_next_state = ST_DONE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Registered outputs; core_reset is low exactly while the state is RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_crst_cnt   <= 1'b0;
            r_dm         <= '0;
            r_dm_wen     <= 1'b0;
            r_core_reset <= 1'b1;
            r_finished   <= 1'b0;
            r_timed_out  <= 1'b0;
        end else begin
            r_dm_wen     <= w_xfer;
            r_core_reset <= (w_next_state != ST_RUN);
            r_crst_cnt   <= (r_state == ST_CRST) && !r_crst_cnt;
            if (w_xfer) begin
                r_dm.addr <= r_idx[BYTE_W-1:0];
                r_dm.wdat <= i_in_data;
            end
            if (w_launch) begin
                r_idx <= '0;
            end else if (w_xfer) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            // Done beats timeout when both land on the same cycle.
            if ((r_state == ST_DONE) && i_start) begin
                r_finished  <= 1'b0;
                r_timed_out <= 1'b0;
            end else if (r_state == ST_RUN) begin
                if (i_core_done) begin
                    r_finished <= 1'b1;
                end else if (w_timeout) begin
                    r_timed_out <= 1'b1;
                end
            end
        end
    end

    sat_counter #(
        .W (CYC_W)
    ) u_cycles (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (r_state == ST_CRST),
        .i_enable (r_state == ST_RUN),
        .o_count  (w_cycles)
    );

    assign o_in_ready   = (r_state == ST_LOAD);
    assign o_busy       = (r_state == ST_LOAD) || (r_state == ST_CRST) || (r_state == ST_RUN);
    assign o_dm_wen     = r_dm_wen;
    assign o_dm_addr    = r_dm.addr;
    assign o_dm_wdat    = r_dm.wdat;
    assign o_core_reset = r_core_reset;
    assign o_finished   = r_finished;
    assign o_timed_out  = r_timed_out;
    assign o_cycles     = w_cycles;

endmodule

// File: tb/tb_prog_launcher.sv
// Self-checking bench for prog_launcher: directed scenarios plus random
// traffic, all checked every cycle against a behavioural model.
module tb_prog_launcher;

    localparam int unsigned LL = 4;
    localparam int unsigned TO = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       core_done = 1'b0;
    logic       in_ready, dm_wen, core_reset, busy, finished, timed_out;
    logic [7:0] dm_addr, dm_wdat;
    logic [15:0] cycles;

    prog_launcher #(.LOAD_LEN(LL), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (start),
        .i_in_valid   (in_valid),
        .i_in_data    (in_data),
        .o_in_ready   (in_ready),
        .o_dm_wen     (dm_wen),
        .o_dm_addr    (dm_addr),
        .o_dm_wdat    (dm_wdat),
        .o_core_reset (core_reset),
        .i_core_done  (core_done),
        .o_busy       (busy),
        .o_finished   (finished),
        .o_timed_out  (timed_out),
        .o_cycles     (cycles)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    always @(posedge clk) cyc++;

    // Behavioural model: progress counters instead of a state variable.
    bit m_load = 0;
    bit m_run  = 0;
    int m_hold = 0;
    int m_bytes = 0;
    bit e_wen = 0;
    int e_addr = 0, e_wdat = 0, e_cyc = 0;
    bit e_fin = 0, e_to = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_load = 0; m_run = 0; m_hold = 0; m_bytes = 0;
            e_wen = 0; e_addr = 0; e_wdat = 0; e_cyc = 0; e_fin = 0; e_to = 0;
        end else begin
            e_wen = 0;
            if (m_load) begin
                if (in_valid) begin
                    e_wen = 1; e_addr = m_bytes; e_wdat = int'(in_data);
                    m_bytes++;
                    if (m_bytes == LL) begin m_load = 0; m_hold = 2; end
                end
            end else if (m_hold > 0) begin
                m_hold--; e_cyc = 0;
                if (m_hold == 0) m_run = 1;
            end else if (m_run) begin
                if (e_cyc < 65535) e_cyc++;
                if (core_done) begin m_run = 0; e_fin = 1; end
                else if (e_cyc == TO) begin m_run = 0; e_to = 1; end
            end else if (start) begin
                e_fin = 0; e_to = 0; m_bytes = 0;
                if (LL == 0) m_hold = 2; else m_load = 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int wa_q[$], wd_q[$], wc_q[$];

    always @(negedge clk) begin
        chk("in_ready", int'(in_ready), int'(m_load));
        chk("busy", int'(busy), int'(m_load || (m_hold > 0) || m_run));
        chk("core_reset", int'(core_reset), int'(!m_run));
        chk("dm_wen", int'(dm_wen), int'(e_wen));
        if (e_wen) begin
            chk("dm_addr", int'(dm_addr), e_addr);
            chk("dm_wdat", int'(dm_wdat), e_wdat);
        end
        chk("finished", int'(finished), int'(e_fin));
        chk("timed_out", int'(timed_out), int'(e_to));
        chk("cycles", int'(cycles), e_cyc);
        if (dm_wen) begin
            wa_q.push_back(int'(dm_addr));
            wd_q.push_back(int'(dm_wdat));
            wc_q.push_back(cyc);
        end
    end

    logic [7:0] ld_data [LL];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic clear_log();
        wa_q.delete(); wd_q.delete(); wc_q.delete();
    endtask

    // mode 0: valid held high, 1: valid toggles 1/0, 2: random valid.
    task automatic do_load(input int mode);
        int budget = 300;
        bit v = 1'b0;
        while (m_load && budget > 0) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = ~v;
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            in_data  = v ? ld_data[m_bytes] : 8'($urandom);
            start    = ($urandom_range(0, 3) == 0);
            step();
            budget--;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("load_complete", int'(!m_load), 1);
    endtask

    task automatic wait_run();
        int b = 10;
        while (!m_run && b > 0) begin step(); b--; end
        chk("reach_run", int'(m_run), 1);
    endtask

    // Called on RUN cycle 1; raises core_done during RUN cycle n.
    task automatic done_on(input int n);
        repeat (n - 1) step();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < LL; i++) ld_data[i] = 8'($urandom);
    endtask

    initial begin
        int hold;
        int b;
        #2 rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        chk("rst_core_reset", int'(core_reset), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_cycles", int'(cycles), 0);
        step();

        // Known bytes with valid held high, done on RUN cycle 57.
        ld_data[0] = 8'h11; ld_data[1] = 8'h22; ld_data[2] = 8'h33; ld_data[3] = 8'h44;
        clear_log();
        pulse_start();
        chk("load_ready", int'(in_ready), 1);
        do_load(0);
        hold = 0;
        b = 10;
        while (core_reset && b > 0) begin
            if (busy && !in_ready) hold++;
            step();
            b--;
        end
        chk("crst_len", hold, 2);
        chk("wr_count", wa_q.size(), 4);
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            chk("wr_addr", wa_q[i], i);
            chk("wr_data", wd_q[i], int'(ld_data[i]));
            chk("wr_back_to_back", wc_q[i] - wc_q[0], i);
        end
        done_on(57);
        chk("s57_finished", int'(finished), 1);
        chk("s57_timed_out", int'(timed_out), 0);
        chk("s57_cycles", int'(cycles), 57);
        chk("s57_core_reset", int'(core_reset), 1);
        chk("s57_model_cycles", e_cyc, 57);
        for (int i = 0; i < 5; i++) begin
            core_done = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            step();
        end
        core_done = 1'b0; in_valid = 1'b0;
        chk("done_hold_cycles", int'(cycles), 57);

        // Restart from DONE, toggling valid, then time out.
        fill_random();
        clear_log();
        pulse_start();
        chk("restart_fin_clear", int'(finished), 0);
        do_load(1);
        wait_run();
        chk("tog_count", wa_q.size(), 4);
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            chk("tog_addr", wa_q[i], i);
            chk("tog_data", wd_q[i], int'(ld_data[i]));
        end
        b = 200;
        while (m_run && b > 0) begin
            start = ($urandom_range(0, 3) == 0);
            step();
            b--;
        end
        start = 1'b0;
        chk("to_timed_out", int'(timed_out), 1);
        chk("to_finished", int'(finished), 0);
        chk("to_cycles", int'(cycles), 100);

        // core_done on exactly the timeout cycle: done wins.
        fill_random();
        pulse_start();
        do_load(2);
        wait_run();
        done_on(100);
        chk("tie_finished", int'(finished), 1);
        chk("tie_timed_out", int'(timed_out), 0);
        chk("tie_cycles", int'(cycles), 100);

        // Asynchronous reset mid-RUN, then a complete fresh sequence.
        fill_random();
        pulse_start();
        do_load(2);
        wait_run();
        repeat (20) step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", int'(in_ready), 0);
        chk("arst_dm_wen", int'(dm_wen), 0);
        chk("arst_dm_addr", int'(dm_addr), 0);
        chk("arst_dm_wdat", int'(dm_wdat), 0);
        chk("arst_core_reset", int'(core_reset), 1);
        chk("arst_busy", int'(busy), 0);
        chk("arst_finished", int'(finished), 0);
        chk("arst_timed_out", int'(timed_out), 0);
        chk("arst_cycles", int'(cycles), 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        fill_random();
        pulse_start();
        do_load(2);
        wait_run();
        done_on(10);
        chk("post_rst_finished", int'(finished), 1);
        chk("post_rst_cycles", int'(cycles), 10);

        // Random traffic with one asynchronous reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 15) == 0);
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            core_done = ($urandom_range(0, 49) == 0);
            if (i == 1500) begin
                #2 rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end
        start = 1'b0; in_valid = 1'b0; core_done = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_launcher.md
PROG_LAUNCHER -- requirements
Module: prog_launcher

Interface
REQ-001 SHALL have parameter LOAD_LEN, default 64, meaning the number of data-memory bytes preloaded per run (legal range 0..256).
REQ-002 SHALL have parameter TIMEOUT, default 4095, meaning the maximum RUN cycles before abort (legal range 1..65535).
REQ-003 clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to begin a load-and-run sequence.
REQ-006 in_valid  in  1  upstream byte valid.
REQ-007 in_data  in  8  upstream preload byte.
REQ-008 in_ready  out  1  launcher accepts a byte this cycle.
REQ-009 dm_wen  out  1  data-memory write enable to the core.
REQ-010 dm_addr  out  8  data-memory write address.
REQ-011 dm_wdat  out  8  data-memory write data.
REQ-012 core_reset  out  1  active-high reset driven into the processor top.
REQ-013 core_done  in  1  processor done flag.
REQ-014 busy  out  1  sequence in progress.
REQ-015 finished  out  1  last run ended on core_done.
REQ-016 timed_out  out  1  last run ended on timeout.
REQ-017 cycles  out  16  RUN cycle count of the current or last run.

Function
REQ-018 SHALL implement the FSM states IDLE, LOAD, CRST, RUN and DONE.
REQ-019 IDLE SHALL hold in_ready=0 and core_reset=1, and start SHALL move to LOAD with the byte index cleared to 0, or to CRST when LOAD_LEN=0.
REQ-020 LOAD SHALL drive in_ready=1, and a transfer SHALL occur only on a cycle where in_valid and in_ready are both 1.
REQ-021 Each transfer SHALL produce, on the next cycle, dm_wen=1 for exactly one cycle with dm_addr equal to the index and dm_wdat equal to in_data; the index SHALL then increment.
REQ-022 The LOAD_LEN-th transfer SHALL move to CRST, and in_ready SHALL be 0 from the following cycle.
REQ-023 CRST SHALL hold core_reset=1 for exactly 2 cycles, clear cycles to 0, and then enter RUN.
REQ-024 RUN SHALL drive core_reset=0 and increment cycles by 1 every cycle, saturating at 16'hFFFF.
REQ-025 core_done SHALL be sampled only in RUN; a high sample SHALL move to DONE with finished=1.
REQ-026 cycles reaching TIMEOUT in RUN SHALL move to DONE with timed_out=1.
REQ-027 When core_done is high on the same cycle that TIMEOUT is reached, done SHALL win: finished=1 and timed_out=0.
REQ-028 DONE SHALL hold core_reset=1 and keep finished, timed_out and cycles stable until the next start.
REQ-029 start in DONE SHALL clear finished and timed_out, and then behave exactly as start in IDLE.
REQ-030 start SHALL be ignored in LOAD, CRST and RUN.
REQ-031 busy SHALL be 1 exactly in LOAD, CRST and RUN.
REQ-032 In LOAD, in_data SHALL be ignored whenever in_valid=0, and no stall duration SHALL time out.

Reset
REQ-033 Asserting reset low SHALL immediately force state IDLE, index=0, cycles=0, dm_wen=0, dm_addr=0, dm_wdat=0, in_ready=0, core_reset=1, busy=0, finished=0 and timed_out=0, including mid-LOAD and mid-RUN.
REQ-034 After release, the first active transition SHALL occur on the first rising edge at which reset is sampled high.

Structure
REQ-035 The state enum, the byte/address width of 8 and the cycle width of 16 SHALL live in the shared package launcher_pkg.
REQ-036 The saturating cycle counter SHALL be the sub-module sat_counter (clear, enable, saturate).
REQ-037 All outputs SHALL be registered except in_ready and busy, which SHALL decode directly from the state.

Verification
REQ-038 Scenario: LOAD_LEN=4, start, bytes 11/22/33/44 with valid held high -> dm writes to addresses 0..3 with data 11,22,33,44 on consecutive cycles, then core_reset high for 2 cycles.
REQ-039 Scenario: in_valid toggling 1/0 during LOAD -> exactly LOAD_LEN writes occur, with no duplicate or skipped address.
REQ-040 Scenario: core_done asserted on RUN cycle 57 -> finished=1, timed_out=0, cycles=57, and core_reset returns to 1.
REQ-041 Scenario: TIMEOUT=100 with core_done never asserted -> timed_out=1 and cycles=100.
REQ-042 Scenario: TIMEOUT=100 with core_done asserted on cycle 100 -> finished=1 and timed_out=0.
REQ-043 Scenario: reset driven low mid-RUN, then start after release -> all outputs at reset values asynchronously, and a full new sequence completes.
